// File: rtl/touch_packet_rx.sv
// Touch-controller serial link receiver: rxd synchronizer, 8N1 UART and 5-byte report parser.
// Delivers pen state and 12-bit X/Y with a one-cycle valid strobe.
`timescale 1ns/1ps
module touch_packet_rx #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    output logic        touch_valid,
    output logic        touch_pen,
    output logic [11:0] touch_x,
    output logic [11:0] touch_y,
    output logic        frame_err,
    output logic        pkt_err
);
    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

    localparam logic [2:0] U_IDLE      = 3'd0;
    localparam logic [2:0] U_START     = 3'd1;
    localparam logic [2:0] U_DATA      = 3'd2;
    localparam logic [2:0] U_STOP      = 3'd3;
    localparam logic [2:0] U_WAIT_HIGH = 3'd4;

    localparam logic [2:0] P_IDLE = 3'd0;
    localparam logic [2:0] P_B1   = 3'd1;
    localparam logic [2:0] P_B2   = 3'd2;
    localparam logic [2:0] P_B3   = 3'd3;
    localparam logic [2:0] P_B4   = 3'd4;

    logic          sync1_d, sync1_q, rxs_d, rxs_q;
    logic [2:0]    ustate_d, ustate_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic [2:0]    bit_idx_d, bit_idx_q;
    logic [7:0]    shift_d, shift_q;
    logic          byte_rdy_d, byte_rdy_q;
    logic          frame_err_d, frame_err_q;

    logic [2:0]    pstate_d, pstate_q;
    logic          pen_sh_d, pen_sh_q;
    logic [11:0]   x_sh_d, x_sh_q;
    logic [6:0]    y_sh_d, y_sh_q;
    logic          touch_valid_d, touch_valid_q;
    logic          pkt_err_d, pkt_err_q;
    logic          touch_pen_d, touch_pen_q;
    logic [11:0]   touch_x_d, touch_x_q;
    logic [11:0]   touch_y_d, touch_y_q;

    logic          cnt_zero;
    logic [7:0]    rx_byte;

    always_comb begin
        sync1_d = rxd;
        rxs_d   = sync1_q;
    end

    // UART receiver: the counter times half a bit to the start-bit centre, then whole bits.
    always_comb begin
        ustate_d    = ustate_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_rdy_d  = 1'b0;
        frame_err_d = 1'b0;
        cnt_zero    = (cnt_q == '0);
        case (ustate_q)
            U_IDLE: begin
                if (!rxs_q) begin
                    ustate_d = U_START;
                    cnt_d    = HALF_LOAD;
                end
            end
            U_START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rxs_q) begin
                    ustate_d  = U_DATA;
                    cnt_d     = FULL_LOAD;
                    bit_idx_d = '0;
                end else begin
                    ustate_d = U_IDLE;
                end
            end
            U_DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    cnt_d   = FULL_LOAD;
                    if (bit_idx_q == 3'd7) begin
                        ustate_d = U_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            U_STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxs_q) begin
                    byte_rdy_d = 1'b1;
                    ustate_d   = U_IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    ustate_d    = U_WAIT_HIGH;
                end
            end
            U_WAIT_HIGH: begin
                if (rxs_q) begin
                    ustate_d = U_IDLE;
                end
            end
            default: ustate_d = U_IDLE;
        endcase
    end

    // shift_q holds the completed byte while byte_rdy_q is high (UART is back in idle).
    assign rx_byte = shift_q;

    always_comb begin
        pstate_d      = pstate_q;
        pen_sh_d      = pen_sh_q;
        x_sh_d        = x_sh_q;
        y_sh_d        = y_sh_q;
        touch_valid_d = 1'b0;
        pkt_err_d     = 1'b0;
        touch_pen_d   = touch_pen_q;
        touch_x_d     = touch_x_q;
        touch_y_d     = touch_y_q;
        if (frame_err_q) begin
            pstate_d = P_IDLE;
        end else if (byte_rdy_q) begin
            if (rx_byte[7]) begin
                pkt_err_d = (pstate_q != P_IDLE);
                pen_sh_d  = rx_byte[0];
                pstate_d  = P_B1;
            end else begin
                case (pstate_q)
                    P_B1: begin
                        x_sh_d[6:0] = rx_byte[6:0];
                        pstate_d    = P_B2;
                    end
                    P_B2: begin
                        x_sh_d[11:7] = rx_byte[4:0];
                        pstate_d     = P_B3;
                    end
                    P_B3: begin
                        y_sh_d   = rx_byte[6:0];
                        pstate_d = P_B4;
                    end
                    P_B4: begin
                        touch_pen_d   = pen_sh_q;
                        touch_x_d     = x_sh_q;
                        touch_y_d     = {rx_byte[4:0], y_sh_q};
                        touch_valid_d = 1'b1;
                        pstate_d      = P_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q       <= 1'b1;
            rxs_q         <= 1'b1;
            ustate_q      <= U_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            byte_rdy_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            pstate_q      <= P_IDLE;
            pen_sh_q      <= 1'b0;
            x_sh_q        <= '0;
            y_sh_q        <= '0;
            touch_valid_q <= 1'b0;
            pkt_err_q     <= 1'b0;
            touch_pen_q   <= 1'b0;
            touch_x_q     <= '0;
            touch_y_q     <= '0;
        end else begin
            sync1_q       <= sync1_d;
            rxs_q         <= rxs_d;
            ustate_q      <= ustate_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            byte_rdy_q    <= byte_rdy_d;
            frame_err_q   <= frame_err_d;
            pstate_q      <= pstate_d;
            pen_sh_q      <= pen_sh_d;
            x_sh_q        <= x_sh_d;
            y_sh_q        <= y_sh_d;
            touch_valid_q <= touch_valid_d;
            pkt_err_q     <= pkt_err_d;
            touch_pen_q   <= touch_pen_d;
            touch_x_q     <= touch_x_d;
            touch_y_q     <= touch_y_d;
        end
    end

    assign touch_valid = touch_valid_q;
    assign touch_pen   = touch_pen_q;
    assign touch_x     = touch_x_q;
    assign touch_y     = touch_y_q;
    assign frame_err   = frame_err_q;
    assign pkt_err     = pkt_err_q;

endmodule

// File: tb/tb_touch_packet_rx.sv
// Bench for touch_packet_rx: directed report scenarios plus a randomized byte stream
// checked against a queue-based report model.
`timescale 1ns/1ps
module tb_touch_packet_rx;
    localparam int unsigned CLK_HZ = 160_000;
    localparam int unsigned BAUD   = 10_000;
    localparam real BIT_NS = 160.0;

    typedef struct packed {
        logic [7:0] data;
        logic       ok;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rxd = 1'b1;
    logic        touch_valid, touch_pen, frame_err, pkt_err;
    logic [11:0] touch_x, touch_y;

    touch_packet_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .touch_valid(touch_valid),
        .touch_pen(touch_pen), .touch_x(touch_x), .touch_y(touch_y),
        .frame_err(frame_err), .pkt_err(pkt_err)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: logs reports, counts pulses, flags over-long pulses and output changes
    // that happen without touch_valid.
    logic [24:0] got_q[$];
    int          tv_cyc = 0, fe_cnt = 0, pe_cnt = 0, pulse_viol = 0, hold_viol = 0;
    logic        tv_prev = 1'b0, fe_prev = 1'b0, pe_prev = 1'b0;
    logic [24:0] prev_out = '0;
    always @(negedge clk) begin
        if (!reset) begin
            if (touch_valid) begin
                got_q.push_back({touch_pen, touch_x, touch_y});
                tv_cyc = cyc;
            end
            if (frame_err) fe_cnt++;
            if (pkt_err) pe_cnt++;
            if ((touch_valid && tv_prev) || (frame_err && fe_prev) || (pkt_err && pe_prev) ||
                (touch_valid && pkt_err)) pulse_viol++;
            if (!touch_valid && ({touch_pen, touch_x, touch_y} != prev_out)) hold_viol++;
        end
        tv_prev  = touch_valid;
        fe_prev  = frame_err;
        pe_prev  = pkt_err;
        prev_out = {touch_pen, touch_x, touch_y};
    end

    int          n_cmp = 0, n_fail = 0;
    frame_t      sent_q[$];
    logic [24:0] exp_q[$];
    int          exp_pe, exp_fe, last_start_cyc;
    int          base_rep, base_fe, base_pe, base_pv, base_hv;

    // Report model: a queue collects the bytes of the report in progress.
    task automatic run_model();
        logic [7:0] part[$];
        exp_q.delete();
        exp_pe = 0;
        exp_fe = 0;
        foreach (sent_q[i]) begin
            if (!sent_q[i].ok) begin
                exp_fe++;
                part.delete();
            end else if (sent_q[i].data[7]) begin
                if (part.size() > 0) exp_pe++;
                part.delete();
                part.push_back(sent_q[i].data);
            end else if (part.size() > 0) begin
                part.push_back(sent_q[i].data);
                if (part.size() == 5) begin
                    exp_q.push_back({part[0][0], part[2][4:0], part[1][6:0],
                                     part[4][4:0], part[3][6:0]});
                    part.delete();
                end
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input real bit_ns);
        sent_q.push_back({b, stop_ok});
        rxd = 1'b0;
        last_start_cyc = cyc;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(bit_ns);
        end
        rxd = stop_ok;
        #(bit_ns);
        if (!stop_ok) begin
            rxd = 1'b1;
            #(bit_ns);
        end
    endtask

    task automatic begin_scenario();
        @(negedge clk);
        #2;
        sent_q.delete();
        base_rep = got_q.size();
        base_fe  = fe_cnt;
        base_pe  = pe_cnt;
        base_pv  = pulse_viol;
        base_hv  = hold_viol;
    endtask

    task automatic settle();
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        run_model();
    endtask

    task automatic send_nominal(input real bit_ns);
        send_frame(8'h81, 1'b1, bit_ns);
        send_frame(8'h34, 1'b1, bit_ns);
        send_frame(8'h12, 1'b1, bit_ns);
        send_frame(8'h78, 1'b1, bit_ns);
        send_frame(8'h0F, 1'b1, bit_ns);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({touch_valid, touch_pen, touch_x, touch_y, frame_err, pkt_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0",
                     {touch_valid, touch_pen, touch_x, touch_y, frame_err, pkt_err});
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if ({touch_valid, touch_pen, touch_x, touch_y, frame_err, pkt_err} !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %h want 0",
                     {touch_valid, touch_pen, touch_x, touch_y, frame_err, pkt_err});
        end
    endtask

    task automatic test_nominal();
        begin_scenario();
        send_nominal(BIT_NS);
        settle();
        n_cmp++;
        if (got_q.size() - base_rep !== 1) begin
            n_fail++;
            $display("FAIL nominal_count: got %0d want 1", got_q.size() - base_rep);
        end else begin
            n_cmp++;
            if (got_q[base_rep] !== {1'b1, 12'h934, 12'h7F8}) begin
                n_fail++;
                $display("FAIL nominal_report: got %h want %h", got_q[base_rep],
                         {1'b1, 12'h934, 12'h7F8});
            end
        end
        // Start edge -> 2 sync flops -> 152-cycle stop sample -> byte_rdy -> touch_valid.
        n_cmp++;
        if (tv_cyc - last_start_cyc !== 156) begin
            n_fail++;
            $display("FAIL nominal_latency: got %0d want 156", tv_cyc - last_start_cyc);
        end
        n_cmp++;
        if ((fe_cnt - base_fe) + (pe_cnt - base_pe) !== 0) begin
            n_fail++;
            $display("FAIL nominal_errors: got fe=%0d pe=%0d want 0", fe_cnt - base_fe,
                     pe_cnt - base_pe);
        end
    endtask

    task automatic test_glitch();
        begin_scenario();
        rxd = 1'b0;
        #60;
        rxd = 1'b1;
        #(3 * BIT_NS);
        send_frame(8'h55, 1'b1, BIT_NS);
        settle();
        n_cmp++;
        if ((got_q.size() - base_rep) + (fe_cnt - base_fe) + (pe_cnt - base_pe) !== 0) begin
            n_fail++;
            $display("FAIL glitch_pulses: got rep=%0d fe=%0d pe=%0d want 0",
                     got_q.size() - base_rep, fe_cnt - base_fe, pe_cnt - base_pe);
        end
        n_cmp++;
        if ({touch_pen, touch_x, touch_y} !== {1'b1, 12'h934, 12'h7F8}) begin
            n_fail++;
            $display("FAIL glitch_hold: got %h want %h", {touch_pen, touch_x, touch_y},
                     {1'b1, 12'h934, 12'h7F8});
        end
    endtask

    task automatic test_frame_err();
        begin_scenario();
        send_frame(8'h80, 1'b1, BIT_NS);
        send_frame(8'h01, 1'b1, BIT_NS);
        send_frame(8'h05, 1'b0, BIT_NS);
        send_frame(8'h80, 1'b1, BIT_NS);
        send_frame(8'h7F, 1'b1, BIT_NS);
        send_frame(8'h1F, 1'b1, BIT_NS);
        send_frame(8'h00, 1'b1, BIT_NS);
        send_frame(8'h00, 1'b1, BIT_NS);
        settle();
        n_cmp++;
        if (fe_cnt - base_fe !== 1 || pe_cnt - base_pe !== 0) begin
            n_fail++;
            $display("FAIL frame_err_pulses: got fe=%0d pe=%0d want fe=1 pe=0",
                     fe_cnt - base_fe, pe_cnt - base_pe);
        end
        n_cmp++;
        if (got_q.size() - base_rep !== 1 || got_q[got_q.size()-1] !== {1'b0, 12'hFFF, 12'h000})
        begin
            n_fail++;
            $display("FAIL frame_err_report: got n=%0d last=%h want n=1 %h",
                     got_q.size() - base_rep, got_q[got_q.size()-1], {1'b0, 12'hFFF, 12'h000});
        end
    endtask

    task automatic test_resync();
        begin_scenario();
        send_frame(8'h81, 1'b1, BIT_NS);
        send_frame(8'h10, 1'b1, BIT_NS);
        send_frame(8'h80, 1'b1, BIT_NS);
        send_frame(8'h01, 1'b1, BIT_NS);
        send_frame(8'h00, 1'b1, BIT_NS);
        send_frame(8'h02, 1'b1, BIT_NS);
        send_frame(8'h00, 1'b1, BIT_NS);
        settle();
        n_cmp++;
        if (pe_cnt - base_pe !== 1 || fe_cnt - base_fe !== 0) begin
            n_fail++;
            $display("FAIL resync_pkt_err: got pe=%0d fe=%0d want pe=1 fe=0",
                     pe_cnt - base_pe, fe_cnt - base_fe);
        end
        n_cmp++;
        if (got_q.size() - base_rep !== 1 || got_q[got_q.size()-1] !== {1'b0, 12'h001, 12'h002})
        begin
            n_fail++;
            $display("FAIL resync_report: got n=%0d last=%h want n=1 %h",
                     got_q.size() - base_rep, got_q[got_q.size()-1], {1'b0, 12'h001, 12'h002});
        end
    endtask

    // Sample points drift by (T-16)*(k+1) cycles; +-0.5 cycle per bit (about 3%) keeps the
    // stop-bit sample inside its bit, so fractional periods are used here.
    task automatic test_baud_tolerance();
        begin_scenario();
        send_nominal(155.0);
        send_nominal(165.0);
        settle();
        n_cmp++;
        if (got_q.size() - base_rep !== 2) begin
            n_fail++;
            $display("FAIL baud_count: got %0d want 2", got_q.size() - base_rep);
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (got_q[base_rep+i] !== {1'b1, 12'h934, 12'h7F8}) begin
                    n_fail++;
                    $display("FAIL baud_report%0d: got %h want %h", i, got_q[base_rep+i],
                             {1'b1, 12'h934, 12'h7F8});
                end
            end
        end
        n_cmp++;
        if ((fe_cnt - base_fe) + (pe_cnt - base_pe) !== 0) begin
            n_fail++;
            $display("FAIL baud_errors: got fe=%0d pe=%0d want 0", fe_cnt - base_fe,
                     pe_cnt - base_pe);
        end
    endtask

    task automatic test_reset_mid_report();
        begin_scenario();
        send_frame(8'h81, 1'b1, BIT_NS);
        send_frame(8'h22, 1'b1, BIT_NS);
        rxd = 1'b0;
        #(BIT_NS);
        rxd = 1'b1;
        #(BIT_NS);
        rxd = 1'b0;
        #(BIT_NS / 2.0);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({touch_valid, touch_pen, touch_x, touch_y, frame_err, pkt_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %h want 0",
                     {touch_valid, touch_pen, touch_x, touch_y, frame_err, pkt_err});
        end
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        begin_scenario();
        send_frame(8'h81, 1'b1, BIT_NS);
        send_frame(8'h05, 1'b1, BIT_NS);
        send_frame(8'h03, 1'b1, BIT_NS);
        send_frame(8'h06, 1'b1, BIT_NS);
        send_frame(8'h01, 1'b1, BIT_NS);
        settle();
        n_cmp++;
        if (got_q.size() - base_rep !== 1 || got_q[got_q.size()-1] !== {1'b1, 12'h185, 12'h086})
        begin
            n_fail++;
            $display("FAIL reset_mid_report: got n=%0d last=%h want n=1 %h",
                     got_q.size() - base_rep, got_q[got_q.size()-1], {1'b1, 12'h185, 12'h086});
        end
    endtask

    task automatic test_random_stream();
        real         bit_ns;
        logic [7:0]  b;
        int          n_got;
        begin_scenario();
        case ($urandom_range(2))
            0:       bit_ns = 155.0;
            1:       bit_ns = 160.0;
            default: bit_ns = 165.0;
        endcase
        for (int i = 0; i < 80; i++) begin
            b = 8'($urandom);
            b[7] = ($urandom_range(99) < 25);
            send_frame(b, ($urandom_range(99) >= 8), bit_ns);
            rxd = 1'b1;
            #($urandom_range(2) * bit_ns);
        end
        settle();
        n_got = got_q.size() - base_rep;
        n_cmp++;
        if (n_got !== exp_q.size()) begin
            n_fail++;
            $display("FAIL random_count: got %0d want %0d", n_got, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
            n_cmp++;
            if (got_q[base_rep+i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL random_report%0d: got %h want %h", i, got_q[base_rep+i], exp_q[i]);
            end
        end
        n_cmp++;
        if (pe_cnt - base_pe !== exp_pe) begin
            n_fail++;
            $display("FAIL random_pkt_err: got %0d want %0d", pe_cnt - base_pe, exp_pe);
        end
        n_cmp++;
        if (fe_cnt - base_fe !== exp_fe) begin
            n_fail++;
            $display("FAIL random_frame_err: got %0d want %0d", fe_cnt - base_fe, exp_fe);
        end
    endtask

    task automatic test_pulse_rules();
        n_cmp++;
        if (pulse_viol !== 0) begin
            n_fail++;
            $display("FAIL pulse_width: got %0d violations want 0", pulse_viol);
        end
        n_cmp++;
        if (hold_viol !== 0) begin
            n_fail++;
            $display("FAIL output_hold: got %0d unstrobed changes want 0", hold_viol);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_glitch();
        test_frame_err();
        test_resync();
        test_baud_tolerance();
        test_reset_mid_report();
        test_random_stream();
        test_pulse_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
